vedic_seq_mult16: RTL and testbench

Iterative multi-cycle multiplier that computes a WIDTH x WIDTH unsigned product using a single instance of the team's 4x4 Vedic core, `mult_4bit`. The block sits directly around that core. It slices latched operands into nibbles, feeds one nibble pair to the core per cycle, and shifts and accumulates the 8-bit core result into a 2*WIDTH accumulator. It is the area-optimised alternative to the fully combinational wide Vedic tree, for paths that tolerate multi-cycle latency.

---
 rtl/vedic_seq_mult16_if.sv | 27 ++
 rtl/mult_4bit.sv | 33 +++
 rtl/vedic_seq_mult16.sv | 153 +++++++++++++++
 tb/tb_vedic_seq_mult16.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_seq_mult16_if.sv
// Request/result bundle for the sequential Vedic multiplier.
//   start   : request, sampled only while the multiplier is idle
//   a, b    : operands, sampled together with an accepted start
//   busy    : high while a multiplication is in progress
//   done    : single-cycle completion pulse
//   product : last completed result, held until the next completion
// master drives requests and observes results; slave is the multiplier side.
interface vedic_seq_mult16_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_4bit.sv
// 4x4 unsigned Vedic (Urdhva Tiryakbhyam) multiplier core, purely combinational.
//   a_i : 4-bit multiplicand
//   b_i : 4-bit multiplier
//   p_o : 8-bit product
// Built from four 2x2 Vedic cells whose crosswise partials are recombined.
module mult_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    // 2x2 Vedic cell: vertical and crosswise bit products with a half-adder chain.
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, c1, t3;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        c1 = t1 & t2;
        t3 = x[1] & y[1];
        return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
    endfunction

    logic [3:0] q_ll_c, q_hl_c, q_lh_c, q_hh_c;

    assign q_ll_c = vedic2(a_i[1:0], b_i[1:0]);
    assign q_hl_c = vedic2(a_i[3:2], b_i[1:0]);
    assign q_lh_c = vedic2(a_i[1:0], b_i[3:2]);
    assign q_hh_c = vedic2(a_i[3:2], b_i[3:2]);

    // Crosswise terms carry weight 4, the high-high term weight 16.
    assign p_o = 8'(q_ll_c)
               + (8'(q_hl_c) << 2)
               + (8'(q_lh_c) << 2)
               + (8'(q_hh_c) << 4);
endmodule

// File: rtl/vedic_seq_mult16.sv
// Iterative WIDTH x WIDTH unsigned multiplier around a single mult_4bit core.
// One nibble pair is multiplied per cycle and shift-accumulated into a
// 2*WIDTH accumulator; a full product takes N*N cycles (N = WIDTH/4).
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : vedic_seq_mult16_if.slave (start, a, b in; busy, done, product out)
// Optional feature macro: VEDIC_SEQ_ZERO_SKIP_EN -- a start with a zero
// operand completes after one edge with product 0 instead of N*N edges.
module vedic_seq_mult16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vedic_seq_mult16_if.slave     bus
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [IW-1:0]    i_q, i_d;
    logic [IW-1:0]    j_q, j_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    logic             skip_q, skip_d;
`endif

    logic [3:0]       nib_a_c, nib_b_c;
    logic [7:0]       pp_c;
    logic [IW:0]      pos_c;
    logic [IW+2:0]    shamt_c;
    logic [PW-1:0]    acc_sum_c;
    logic             last_c;

    // Nibble select, core, and weighted accumulate: one cycle, no pipelining.
    assign nib_a_c   = 4'(a_q >> {i_q, 2'b00});
    assign nib_b_c   = 4'(b_q >> {j_q, 2'b00});
    assign pos_c     = {1'b0, i_q} + {1'b0, j_q};
    assign shamt_c   = {pos_c, 2'b00};
    assign acc_sum_c = acc_q + (PW'(pp_c) << shamt_c);
    assign last_c    = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));

    mult_4bit u_core (
        .a_i (nib_a_c),
        .b_i (nib_b_c),
        .p_o (pp_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            skip_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            i_q       <= i_d;
            j_q       <= j_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            skip_q    <= skip_d;
`endif
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        i_d       = i_q;
        j_d       = j_q;
        done_d    = 1'b0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        skip_d    = skip_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                    skip_d  = (bus.a == '0) || (bus.b == '0);
`endif
                end
            end

            S_RUN: begin
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                if (skip_q) begin
                    product_d = '0;
                    done_d    = 1'b1;
                    skip_d    = 1'b0;
                    state_d   = S_IDLE;
                end else
`endif
                begin
                    acc_d = acc_sum_c;
                    if (last_c) begin
                        product_d = acc_sum_c;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else if (j_q == IW'(N - 1)) begin
                        // j is the inner index; its wrap advances i.
                        j_d = '0;
                        i_d = i_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_vedic_seq_mult16.sv
module tb_vedic_seq_mult16;
    localparam int unsigned W   = 16;
    localparam int          LAT = (W / 4) * (W / 4);

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    vedic_seq_mult16_if #(.WIDTH(W)) bus ();

    vedic_seq_mult16 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    // Reference latency and result, straight from the arithmetic definition.
    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (ZSKIP && (a == '0 || b == '0)) return 1;
        return LAT;
    endfunction

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    // Present a start for the next edge (E0), then scramble the operand inputs.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Count edges after E0 until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (bus.done === 1'b1) return;
        end
        $display("FAIL wait_done: no done within %0d edges", n);
    endtask

    // One full operation with latency, result, busy and pulse-width checks.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        launch(a, b);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++; $display("FAIL %s busy_after_E0: got %b want 1", name, bus.busy);
        end
        wait_done(n);
        tests++;
        if (n !== ref_lat(a, b)) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", name, n, ref_lat(a, b));
        end
        tests++;
        if (bus.product !== ref_prod(a, b)) begin
            fails++; $display("FAIL %s product: got %h want %h", name, bus.product, ref_prod(a, b));
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++; $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            fails++;
            $display("FAIL reset_values: busy=%b done=%b product=%h want 0 0 0",
                     bus.busy, bus.done, bus.product);
        end
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL idle_quiet: got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_basic();
        run_op("basic", 16'h1234, 16'h5678);
        tests++;
        if (bus.product !== 32'h0626_0060) begin
            fails++; $display("FAIL basic_const: got %h want 06260060", bus.product);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b0) begin
            fails++; $display("FAIL basic_pulse_width: got %b want 0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        run_op("max", 16'hFFFF, 16'hFFFF);
        tests++;
        if (bus.product !== 32'hFFFE_0001) begin
            fails++; $display("FAIL max_const: got %h want fffe0001", bus.product);
        end
        launch(16'h0003, 16'h0005);
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        tests++;
        if (bus.product !== 32'hFFFE_0001) begin
            fails++; $display("FAIL b2b_product_hold: got %h want fffe0001", bus.product);
        end
        wait_done(n);
        tests++;
        if (n !== LAT || bus.product !== 32'h0000_000F) begin
            fails++; $display("FAIL b2b_result: lat=%0d product=%h want %0d 0000000f", n, bus.product, LAT);
        end
    endtask

    task automatic test_mid_run_start();
        int n;
        launch(16'h00FF, 16'h0100);
        n = 0;
        while (n < 60) begin
            if (n == 4) begin
                bus.start = 1'b1;
                bus.a = 16'hFFFF;
                bus.b = 16'hFFFF;
            end
            @(posedge clk); #1;
            n++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) break;
        end
        tests++;
        if (n !== LAT || bus.product !== 32'h0000_FF00) begin
            fails++; $display("FAIL midrun_ignore: lat=%0d product=%h want %0d 0000ff00", n, bus.product, LAT);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL midrun_no_queue: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mid_run_reset();
        int pulses;
        launch(16'h00FF, 16'h0100);
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%h want 0 0 0",
                     bus.busy, bus.done, bus.product);
        end
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL midrun_reset_no_done: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_zero();
        run_op("zero_a", 16'h0000, 16'hABCD);
        run_op("zero_b", 16'h1357, 16'h0000);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int k = 0; k < 12; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (k == 3) a = '0;
            if (k == 7) b = '0;
            if (k == 9) a = 16'h8000;
            run_op("random", a, b);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_mid_run_start();
        test_mid_run_reset();
        test_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
